// File: rtl/hyper_pipe_sink.sv
// Receive endpoint for a hyper-piped valid-only stream: skid FIFO with show-ahead ready/valid output.
// Optional statistics counters are enabled with `define HYPER_PIPE_SINK_STATS_EN.
module hyper_pipe_sink #(
    parameter int unsigned WIDTH     = 512,
    parameter int unsigned EMPTY_W   = 6,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned NUM_PIPES = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_sop,
    input  logic                     in_eop,
    input  logic [WIDTH-1:0]         in_data,
    input  logic [EMPTY_W-1:0]       in_empty,
    input  logic                     in_valid,
    output logic                     almost_full,
    output logic                     out_sop,
    output logic                     out_eop,
    output logic [WIDTH-1:0]         out_data,
    output logic [EMPTY_W-1:0]       out_empty,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     overflow,
    output logic [$clog2(DEPTH):0]   occupancy,
    output logic [31:0]              stat_pkt_cnt,
    output logic [31:0]              stat_drop_cnt
);

    localparam int unsigned PTR_W    = $clog2(DEPTH);
    localparam int unsigned OCC_W    = PTR_W + 1;
    localparam int unsigned ENTRY_W  = WIDTH + EMPTY_W + 2;
    // Leaves room for the 2*NUM_PIPES+1 beats still in flight after assertion.
    localparam int unsigned AF_LEVEL = DEPTH - (2 * NUM_PIPES + 2);

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [ENTRY_W-1:0] head;
    logic [OCC_W-1:0]   occ_next;
    logic               full;
    logic               push;
    logic               pop;
    logic               drop;

    assign out_valid = (occupancy != '0);
    assign head      = mem[rd_ptr];
    assign {out_sop, out_eop, out_empty, out_data} = head;

    always_comb begin
        full     = (occupancy == OCC_W'(DEPTH));
        pop      = out_valid && out_ready;
        push     = in_valid && (!full || pop);
        drop     = in_valid && !push;
        occ_next = occupancy;
        case ({push, pop})
            2'b10:   occ_next = occupancy + OCC_W'(1);
            2'b01:   occ_next = occupancy - OCC_W'(1);
            default: occ_next = occupancy;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {in_sop, in_eop, in_empty, in_data};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            occupancy   <= '0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (drop) begin
                overflow <= 1'b1;
            end
            occupancy   <= occ_next;
            almost_full <= (occ_next >= OCC_W'(AF_LEVEL));
        end
    end

`ifdef HYPER_PIPE_SINK_STATS_EN
    logic [31:0] pkt_cnt;
    logic [31:0] drop_cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            pkt_cnt  <= '0;
            drop_cnt <= '0;
        end else begin
            if (push && in_eop) begin
                pkt_cnt <= pkt_cnt + 32'd1;
            end
            if (drop && (drop_cnt != '1)) begin
                drop_cnt <= drop_cnt + 32'd1;
            end
        end
    end

    assign stat_pkt_cnt  = pkt_cnt;
    assign stat_drop_cnt = drop_cnt;
`else
    assign stat_pkt_cnt  = '0;
    assign stat_drop_cnt = '0;
`endif

endmodule

// File: tb/tb_hyper_pipe_sink.sv
// Self-checking bench for hyper_pipe_sink: directed table, corner sequences and a randomized
// piped-upstream run checked against a queue-based reference model.
module tb_hyper_pipe_sink;

    localparam int WIDTH     = 512;
    localparam int EMPTY_W   = 6;
    localparam int DEPTH     = 16;
    localparam int NUM_PIPES = 1;
    localparam int AF_LEVEL  = DEPTH - (2 * NUM_PIPES + 2);
    localparam int LAT       = 1 + NUM_PIPES;
`ifdef HYPER_PIPE_SINK_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic                   clk;
    logic                   rst;
    logic                   in_sop;
    logic                   in_eop;
    logic [WIDTH-1:0]       in_data;
    logic [EMPTY_W-1:0]     in_empty;
    logic                   in_valid;
    logic                   almost_full;
    logic                   out_sop;
    logic                   out_eop;
    logic [WIDTH-1:0]       out_data;
    logic [EMPTY_W-1:0]     out_empty;
    logic                   out_valid;
    logic                   out_ready;
    logic                   overflow;
    logic [$clog2(DEPTH):0] occupancy;
    logic [31:0]            stat_pkt_cnt;
    logic [31:0]            stat_drop_cnt;

    hyper_pipe_sink #(
        .WIDTH     (WIDTH),
        .EMPTY_W   (EMPTY_W),
        .DEPTH     (DEPTH),
        .NUM_PIPES (NUM_PIPES)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .in_sop        (in_sop),
        .in_eop        (in_eop),
        .in_data       (in_data),
        .in_empty      (in_empty),
        .in_valid      (in_valid),
        .almost_full   (almost_full),
        .out_sop       (out_sop),
        .out_eop       (out_eop),
        .out_data      (out_data),
        .out_empty     (out_empty),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .overflow      (overflow),
        .occupancy     (occupancy),
        .stat_pkt_cnt  (stat_pkt_cnt),
        .stat_drop_cnt (stat_drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic               sop;
        logic               eop;
        logic [EMPTY_W-1:0] empty;
        logic [WIDTH-1:0]   data;
    } beat_t;

    // Reference model: a queue of stored beats plus sticky/statistic state.
    beat_t       mq[$];
    bit          m_ovf;
    logic [31:0] m_pkt;
    logic [31:0] m_drop;

    int checks = 0;
    int errors = 0;

    // Upstream model: send decision registered once, then NUM_PIPES stages; almost_full seen NUM_PIPES late.
    beat_t line   [LAT];
    bit    line_v [LAT];
    bit    af_dly [NUM_PIPES];
    int    pkt_pos;
    int    pkts_sent;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_beat(input string name, input beat_t exp);
        beat_t act;
        act = {out_sop, out_eop, out_empty, out_data};
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [WIDTH-1:0] rand_data();
        logic [WIDTH-1:0] d;
        for (int i = 0; i < WIDTH / 32; i++) d[i*32 +: 32] = $urandom;
        return d;
    endfunction

    task automatic set_in(input bit v, input beat_t b);
        in_valid = v;
        {in_sop, in_eop, in_empty, in_data} = b;
    endtask

    // One clock: predict from the spec rules, advance, sample #1 after the edge.
    task automatic tick();
        bit    pop, push, drop, r;
        beat_t b;
        r    = rst;
        b    = {in_sop, in_eop, in_empty, in_data};
        pop  = (mq.size() != 0) && out_ready;
        push = in_valid && ((mq.size() < DEPTH) || pop);
        drop = in_valid && !push;
        @(posedge clk);
        #1;
        if (r) begin
            mq.delete();
            m_ovf  = 1'b0;
            m_pkt  = '0;
            m_drop = '0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (push) begin
                mq.push_back(b);
                if (b.eop) m_pkt = m_pkt + 32'd1;
            end
            if (drop) begin
                m_ovf = 1'b1;
                if (m_drop != 32'hFFFF_FFFF) m_drop = m_drop + 32'd1;
            end
        end
    endtask

    task automatic compare_all();
        chk("out_valid", out_valid, (mq.size() != 0));
        chk("occupancy", occupancy, mq.size());
        chk("almost_full", almost_full, (mq.size() >= AF_LEVEL));
        chk("overflow", overflow, m_ovf);
        if (mq.size() != 0) chk_beat("head", mq[0]);
        chk("stat_pkt_cnt", stat_pkt_cnt, STATS ? m_pkt : 32'd0);
        chk("stat_drop_cnt", stat_drop_cnt, STATS ? m_drop : 32'd0);
    endtask

    task automatic up_reset();
        for (int i = 0; i < LAT; i++) begin
            line_v[i] = 1'b0;
            line[i]   = '0;
        end
        for (int i = 0; i < NUM_PIPES; i++) af_dly[i] = 1'b0;
        pkt_pos = 0;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        out_ready = 1'b0;
        set_in(1'b0, '0);
        tick();
        tick();
        rst = 1'b0;
        up_reset();
    endtask

    task automatic run_upstream(input int cycles, input int send_pct, input int ready_pct);
        bit    af_seen, send;
        beat_t nb;
        for (int c = 0; c < cycles; c++) begin
            set_in(line_v[LAT-1], line[LAT-1]);
            af_seen = af_dly[NUM_PIPES-1];
            for (int i = NUM_PIPES - 1; i > 0; i--) af_dly[i] = af_dly[i-1];
            af_dly[0] = almost_full;
            send = !af_seen && ($urandom_range(99) < send_pct);
            for (int i = LAT - 1; i > 0; i--) begin
                line[i]   = line[i-1];
                line_v[i] = line_v[i-1];
            end
            nb       = '0;
            if (send) begin
                nb.sop   = (pkt_pos == 0);
                nb.eop   = (pkt_pos == 2);
                nb.empty = nb.eop ? EMPTY_W'($urandom) : '0;
                nb.data  = rand_data();
                pkt_pos  = (pkt_pos + 1) % 3;
                if (nb.eop) pkts_sent++;
            end
            line[0]   = nb;
            line_v[0] = send;
            out_ready = ($urandom_range(99) < ready_pct);
            tick();
            compare_all();
        end
    endtask

    task automatic push_direct(input int n, input bit rdy);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.sop   = (i % 3 == 0);
            b.eop   = (i % 3 == 2);
            b.empty = EMPTY_W'(i);
            b.data  = rand_data();
            set_in(1'b1, b);
            out_ready = rdy;
            tick();
            compare_all();
        end
        set_in(1'b0, '0);
    endtask

    typedef struct {
        bit               v;
        bit               sop;
        bit               eop;
        logic [7:0]       d;
        logic [EMPTY_W-1:0] emp;
        bit               rdy;
        bit               e_valid;
        int               e_occ;
        logic [7:0]       e_d;
        bit               e_sop;
        bit               e_eop;
        logic [EMPTY_W-1:0] e_emp;
    } vec_t;

    vec_t  vecs [9];
    beat_t vb;
    beat_t eb;

    initial begin
        vecs[0] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 6'd0};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 8'hA5, 6'd5, 1'b0, 1'b1, 1, 8'hA5, 1'b1, 1'b1, 6'd5};
        vecs[2] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b0, 1'b1, 1, 8'hA5, 1'b1, 1'b1, 6'd5};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 6'd0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 8'h3C, 6'd0, 1'b1, 1'b1, 1, 8'h3C, 1'b1, 1'b0, 6'd0};
        vecs[5] = '{1'b1, 1'b0, 1'b0, 8'h5A, 6'd0, 1'b1, 1'b1, 1, 8'h5A, 1'b0, 1'b0, 6'd0};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 8'h77, 6'd3, 1'b0, 1'b1, 2, 8'h5A, 1'b0, 1'b0, 6'd0};
        vecs[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b1, 1'b1, 1, 8'h77, 1'b0, 1'b1, 6'd3};
        vecs[8] = '{1'b0, 1'b0, 1'b0, 8'h00, 6'd0, 1'b1, 1'b0, 0, 8'h00, 1'b0, 1'b0, 6'd0};
        pkts_sent = 0;
        up_reset();

        // Reset state
        do_reset();
        chk("rst_out_valid", out_valid, 0);
        chk("rst_occupancy", occupancy, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_stat_pkt", stat_pkt_cnt, 0);
        chk("rst_stat_drop", stat_drop_cnt, 0);

        // Directed table: single beat latency, empty-with-ready, no bypass, simultaneous push/pop
        for (int i = 0; i < 9; i++) begin
            vb.sop   = vecs[i].sop;
            vb.eop   = vecs[i].eop;
            vb.empty = vecs[i].emp;
            vb.data  = {(WIDTH/8){vecs[i].d}};
            set_in(vecs[i].v, vb);
            out_ready = vecs[i].rdy;
            tick();
            chk("vec_valid", out_valid, vecs[i].e_valid);
            chk("vec_occ", occupancy, vecs[i].e_occ);
            if (vecs[i].e_valid) begin
                eb.sop   = vecs[i].e_sop;
                eb.eop   = vecs[i].e_eop;
                eb.empty = vecs[i].e_emp;
                eb.data  = {(WIDTH/8){vecs[i].e_d}};
                chk_beat("vec_head", eb);
            end
            compare_all();
        end
        set_in(1'b0, '0);

        // Continuous upstream honouring almost_full with no consumer: settles at AF_LEVEL + 2*NUM_PIPES+1
        do_reset();
        run_upstream(30, 100, 0);
        chk("af_fill_occ", occupancy, 15);
        chk("af_fill_af", almost_full, 1);
        chk("af_fill_ovf", overflow, 0);

        // Fill to full, then two beats with no pop are dropped
        do_reset();
        push_direct(DEPTH, 1'b0);
        chk("full_occ", occupancy, DEPTH);
        push_direct(2, 1'b0);
        chk("drop_ovf", overflow, 1);
        chk("drop_occ", occupancy, DEPTH);
        chk("drop_cnt", stat_drop_cnt, STATS ? 32'd2 : 32'd0);

        // Full with push and pop every cycle: occupancy holds, pointers wrap, order preserved
        for (int c = 0; c < 40; c++) begin
            push_direct(1, 1'b1);
            chk("full_pp_occ", occupancy, DEPTH);
        end
        out_ready = 1'b1;
        for (int c = 0; c < DEPTH + 2; c++) begin
            tick();
            compare_all();
        end
        chk("drain_occ", occupancy, 0);
        chk("drain_drop_cnt", stat_drop_cnt, STATS ? 32'd2 : 32'd0);

        // Reset mid-packet with 7 entries and overflow still set
        push_direct(7, 1'b0);
        chk("pre_rst_occ", occupancy, 7);
        rst = 1'b1;
        vb  = '0;
        vb.sop = 1'b1;
        set_in(1'b1, vb);
        tick();
        rst = 1'b0;
        set_in(1'b0, '0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_occ", occupancy, 0);
        chk("mid_rst_af", almost_full, 0);
        chk("mid_rst_ovf", overflow, 0);
        compare_all();

        // Random traffic with a piped upstream that honours almost_full
        do_reset();
        pkts_sent = 0;
        run_upstream(10000, 60, 55);
        run_upstream(LAT + 2, 0, 55);
        out_ready = 1'b1;
        for (int c = 0; c < DEPTH + 2; c++) begin
            tick();
            compare_all();
        end
        chk("rand_ovf", overflow, 0);
        chk("rand_drops", stat_drop_cnt, 0);
        chk("rand_occ", occupancy, 0);
        chk("rand_pkts", stat_pkt_cnt, STATS ? 32'(pkts_sent) : 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
